perf_counter_sampler: RTL and testbench

- Synchronous readout stage downstream of the asynchronous event counters; each counter increments on its own event edge, not on clk.
- Samples a selected counter's free-running WIDTH-bit value into the clk domain using a double-read stability check.
- Extends the sample with a software-visible upper word that counts wrap-arounds.
- Returns one result per request to the control-register read path.

---
 rtl/perf_counter_sampler.sv | 157 +++++++++++++++
 tb/tb_perf_counter_sampler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler
// Brings one of several free-running event counters into the clk domain on
// request. The counter is read repeatedly until two consecutive reads agree.
// A per-counter upper word counts wrap-arounds, and {ext, sample} is returned.
// Optional feature: define PERF_COUNTER_SAMPLER_CLEAR_EN to add clear_all.
// clear_all zeroes every last_sample/ext pair.
module perf_counter_sampler #(
  parameter int WIDTH        = 32,
  parameter int NUM_COUNTERS = 4,
  parameter int MAX_RETRIES  = 7,
  parameter int EXT_WIDTH    = 32,
  localparam int IDX_W       = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef PERF_COUNTER_SAMPLER_CLEAR_EN
  input  logic                          clear_all,
`endif
  input  logic [NUM_COUNTERS*WIDTH-1:0] counter_values,
  input  logic                          read_en,
  input  logic [IDX_W-1:0]              read_index,
  output logic                          busy,
  output logic                          read_valid,
  output logic [EXT_WIDTH+WIDTH-1:0]    read_value,
  output logic                          read_error
);

  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);
  localparam logic [IDX_W:0]   NUM_C   = (IDX_W + 1)'(NUM_COUNTERS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state_reg;
  logic [IDX_W-1:0]     index_reg;
  logic [RTY_W-1:0]     retry_reg;
  logic [WIDTH-1:0]     s1_reg;
  logic [WIDTH-1:0]     last_snap_reg;
  logic [EXT_WIDTH-1:0] ext_snap_reg;
  // Set when a clear landed during this read: the read then must not commit.
  logic                 hold_reg;

  logic [WIDTH-1:0]     cnt_arr  [NUM_COUNTERS];
  logic [WIDTH-1:0]     last_arr [NUM_COUNTERS];
  logic [EXT_WIDTH-1:0] ext_arr  [NUM_COUNTERS];

  logic                 clear_now;
  logic                 index_ok;
  logic [WIDTH-1:0]     raw_value;
  logic                 stable;
  logic                 wrap;
  logic [EXT_WIDTH-1:0] ext_new;
  logic                 commit_en;

`ifdef PERF_COUNTER_SAMPLER_CLEAR_EN
  assign clear_now = clear_all;
`else
  assign clear_now = 1'b0;
`endif

  // index_reg is only loaded with in-range values, so these lookups stay in bounds.
  assign index_ok  = {1'b0, read_index} < NUM_C;
  assign raw_value = cnt_arr[index_reg];
  assign stable    = (raw_value == s1_reg);
  assign wrap      = (s1_reg < last_snap_reg);
  assign ext_new   = ext_snap_reg + EXT_WIDTH'(wrap);
  assign commit_en = (state_reg == S_SECOND) && stable && !hold_reg;

  assign busy       = (state_reg != S_IDLE);
  assign read_valid = (state_reg == S_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
      logic [WIDTH-1:0]     last_reg;
      logic [EXT_WIDTH-1:0] ext_reg;

      assign cnt_arr[gi]  = counter_values[gi*WIDTH +: WIDTH];
      assign last_arr[gi] = last_reg;
      assign ext_arr[gi]  = ext_reg;

      // Per-counter wrap tracking. A clear wins over a same-cycle commit.
      always_ff @(posedge clk) begin
        if (reset || clear_now) begin
          last_reg <= '0;
          ext_reg  <= '0;
        end else if (commit_en && (index_reg == IDX_W'(gi))) begin
          last_reg <= s1_reg;
          ext_reg  <= ext_new;
        end
      end
    end
  endgenerate

  // Read sequencer: accept, read twice until stable (bounded retries), present result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      index_reg     <= '0;
      retry_reg     <= '0;
      s1_reg        <= '0;
      last_snap_reg <= '0;
      ext_snap_reg  <= '0;
      hold_reg      <= 1'b0;
      read_value    <= '0;
      read_error    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (read_en) begin
            retry_reg  <= '0;
            hold_reg   <= clear_now;
            read_error <= 1'b0;
            if (index_ok) begin
              // Snapshot the extension state now: the result is computed against pre-clear values.
              index_reg     <= read_index;
              last_snap_reg <= last_arr[read_index];
              ext_snap_reg  <= ext_arr[read_index];
              state_reg     <= S_FIRST;
            end else begin
              read_value <= '0;
              read_error <= 1'b1;
              state_reg  <= S_DONE;
            end
          end
        end
        S_FIRST: begin
          hold_reg  <= hold_reg | clear_now;
          s1_reg    <= raw_value;
          state_reg <= S_SECOND;
        end
        S_SECOND: begin
          hold_reg <= hold_reg | clear_now;
          if (stable) begin
            read_value <= {ext_new, s1_reg};
            read_error <= 1'b0;
            state_reg  <= S_DONE;
          end else if (retry_reg == RTY_MAX) begin
            read_value <= {ext_snap_reg, raw_value};
            read_error <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            s1_reg    <= raw_value;
            retry_reg <= retry_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_sampler.sv
// tb_perf_counter_sampler
// Expected results are queued as each read is issued. A monitor on the falling
// edge pops them and compares them when read_valid appears.
// Compile with PERF_COUNTER_SAMPLER_CLEAR_EN to also cover clear_all.
module tb_perf_counter_sampler;

  localparam int W   = 32;
  localparam int N   = 3;
  localparam int EXT = 32;

  logic               clk = 1'b0;
  logic               reset;
`ifdef PERF_COUNTER_SAMPLER_CLEAR_EN
  logic               clear_all;
`endif
  logic [W-1:0]       cv [N];
  logic [N*W-1:0]     counter_values;
  logic               read_en;
  logic [1:0]         read_index;
  logic               busy;
  logic               read_valid;
  logic [EXT+W-1:0]   read_value;
  logic               read_error;

  typedef struct {
    logic [63:0] val;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  assign counter_values = {cv[2], cv[1], cv[0]};

  perf_counter_sampler #(
    .WIDTH(W), .NUM_COUNTERS(N), .MAX_RETRIES(7), .EXT_WIDTH(EXT)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef PERF_COUNTER_SAMPLER_CLEAR_EN
    .clear_all(clear_all),
`endif
    .counter_values(counter_values),
    .read_en(read_en),
    .read_index(read_index),
    .busy(busy),
    .read_valid(read_valid),
    .read_value(read_value),
    .read_error(read_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%016h exp=0x%016h at cycle %0d", tag, got, exp, cyc);
    end else begin
      $display("ok   %s = 0x%016h at cycle %0d", tag, got, cyc);
    end
  endtask

  // Called at posedge+#1; read_en is sampled by the next edge (cycle 0 = this cycle).
  task automatic issue(input logic [1:0] idx, input logic [63:0] val, input logic err,
                       input int unsigned lat);
    exp_t e;
    e.val = val;
    e.err = err;
    e.cyc = cyc + lat;
    q.push_back(e);
    read_index = idx;
    read_en    = 1'b1;
    @(posedge clk) #1;
    read_en    = 1'b0;
  endtask

  // Bounded wait for every queued result to be consumed; returns at posedge+#1.
  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q.size() != 0 && n < 40);
    check("all_results_seen", 64'(q.size()), 64'd0);
    q.delete();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!reset && read_valid) begin
      if (q.size() == 0) begin
        check("unexpected_read_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("read_value", read_value, e.val);
        check("read_error", 64'(read_error), 64'(e.err));
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_with_valid", 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    read_en    = 1'b0;
    read_index = '0;
`ifdef PERF_COUNTER_SAMPLER_CLEAR_EN
    clear_all  = 1'b0;
`endif
    for (int i = 0; i < N; i++) cv[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(read_valid), 64'd0);
    check("rst_error", 64'(read_error), 64'd0);
    check("rst_value", read_value, 64'd0);

    // Stable read with busy window
    cv[1] = 32'h0000_1234;
    issue(2'd1, 64'h0000_0000_0000_1234, 1'b0, 3);
    check("busy_c1", 64'(busy), 64'd1);
    idle(1);
    check("busy_c2", 64'(busy), 64'd1);
    idle(1);
    check("busy_c3", 64'(busy), 64'd1);
    wait_done();
    check("busy_c4", 64'(busy), 64'd0);

    // Wrap detection, then equal value (no wrap)
    cv[0] = 32'hFFFF_FFF0;
    issue(2'd0, 64'h0000_0000_FFFF_FFF0, 1'b0, 3);
    wait_done();
    cv[0] = 32'h0000_0005;
    issue(2'd0, 64'h0000_0001_0000_0005, 1'b0, 3);
    wait_done();
    issue(2'd0, 64'h0000_0001_0000_0005, 1'b0, 3);
    wait_done();

    // Out-of-range index
    issue(2'd3, 64'd0, 1'b1, 1);
    wait_done();

    // Counter 2 never settles: error after MAX_RETRIES, ext/last untouched
    cv[2] = 32'h0000_0010;
    issue(2'd2, 64'h0000_0000_0000_0010, 1'b0, 3);
    wait_done();
    begin
      exp_t e;
      cv[2] = 32'h0000_0005;
      e.val = 64'h0000_0000_0000_000E;
      e.err = 1'b1;
      e.cyc = cyc + 10;
      q.push_back(e);
      read_index = 2'd2;
      read_en    = 1'b1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk) #1;
        read_en = 1'b0;
        cv[2]   = cv[2] + 1;
      end
    end
    wait_done();
    cv[2] = 32'h0000_0020;
    issue(2'd2, 64'h0000_0000_0000_0020, 1'b0, 3);
    wait_done();

    // One change between FIRST and SECOND: a single retry
    issue(2'd1, 64'h0000_0000_0000_2000, 1'b0, 4);
    idle(1);
    cv[1] = 32'h0000_2000;
    wait_done();

    // read_en while busy is ignored; back-to-back accept when busy falls
    issue(2'd1, 64'h0000_0000_0000_2000, 1'b0, 3);
    idle(1);
    read_index = 2'd0;
    read_en    = 1'b1;
    idle(1);
    read_en    = 1'b0;
    wait_done();
    issue(2'd1, 64'h0000_0000_0000_2000, 1'b0, 3);
    wait_done();
    idle(4);

`ifdef PERF_COUNTER_SAMPLER_CLEAR_EN
    // clear_all zeroes the extension state (ext[0] is 1 here)
    clear_all = 1'b1;
    idle(1);
    clear_all = 1'b0;
    cv[0] = 32'h0000_0010;
    issue(2'd0, 64'h0000_0000_0000_0010, 1'b0, 3);
    wait_done();
`endif

    // Reset in the middle of a read: no read_valid, outputs return to 0
    read_index = 2'd0;
    read_en    = 1'b1;
    idle(1);
    read_en    = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(read_valid), 64'd0);
    check("midrst_error", 64'(read_error), 64'd0);
    check("midrst_value", read_value, 64'd0);
    idle(6);

    // Reset cleared last_sample/ext for counter 0
    cv[0] = 32'h0000_0003;
    issue(2'd0, 64'h0000_0000_0000_0003, 1'b0, 3);
    wait_done();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
